// File: rtl/fp_mult_responder.sv
// Single-precision floating-point multiplier, responder side of the
// start/ready arithmetic handshake. One operand pair is accepted in IDLE,
// walked through UNPACK -> MULT -> NORM -> ROUND, and the rounded (RNE)
// product is returned with a one-cycle ready pulse.
module fp_mult_responder #(
  parameter  int EXP_LEN      = 8,
  parameter  int MANTISSA_LEN = 23,
  localparam int DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mult_start,
  input  logic [DATA_WIDTH-1:0] mult_operand_a,
  input  logic [DATA_WIDTH-1:0] mult_operand_b,
  output logic [DATA_WIDTH-1:0] mult_result,
  output logic                  mult_result_ready,
  output logic                  mult_busy
);

  localparam int ML = MANTISSA_LEN;
  localparam int MW = ML + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * MW;          // full product width
  localparam int EW = EXP_LEN + 2;     // signed exponent width, never wraps
  localparam logic        [EW-1:0] BIAS     = EW'(2**(EXP_LEN-1) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2**EXP_LEN - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(ML-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t   state_q, state_d;
  special_t spec_q, spec_d;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  sign_q, sign_d;
  logic [EXP_LEN-1:0]    ea_q, ea_d, eb_q, eb_d;
  logic [MW-1:0]         ma_q, ma_d, mb_q, mb_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [ML-1:0]         frac_q, frac_d;
  logic                  grd_q, grd_d, rnd_q, rnd_d, stk_q, stk_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  ready_q, ready_d, busy_q, busy_d;

  // Operand field views and IEEE classification of the latched operands.
  logic [EXP_LEN-1:0] ea_f, eb_f;
  logic [ML-1:0]      fa_f, fb_f;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea_f   = a_q[DATA_WIDTH-2 -: EXP_LEN];
  assign eb_f   = b_q[DATA_WIDTH-2 -: EXP_LEN];
  assign fa_f   = a_q[ML-1:0];
  assign fb_f   = b_q[ML-1:0];
  // Exponent field of zero covers both true zero and denormals (flushed).
  assign a_zero = (ea_f == '0);
  assign b_zero = (eb_f == '0);
  assign a_inf  = (&ea_f) && (fa_f == '0);
  assign b_inf  = (&eb_f) && (fb_f == '0);
  assign a_nan  = (&ea_f) && (fa_f != '0);
  assign b_nan  = (&eb_f) && (fb_f != '0);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed five-step walk, start only honoured in IDLE.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (mult_start) state_d = S_UNPACK;
      S_UNPACK: state_d = S_MULT;
      S_MULT:   state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers; all cleared so an aborted op leaves nothing behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      spec_q <= SP_NONE;
      prod_q <= '0;
      exp_q  <= '0;
      frac_q <= '0;
      grd_q  <= 1'b0;
      rnd_q  <= 1'b0;
      stk_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sign_q <= sign_d;
      ea_q   <= ea_d;
      eb_q   <= eb_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      spec_q <= spec_d;
      prod_q <= prod_d;
      exp_q  <= exp_d;
      frac_q <= frac_d;
      grd_q  <= grd_d;
      rnd_q  <= rnd_d;
      stk_q  <= stk_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Per-state datapath step: latch, unpack, multiply, normalise.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sign_d = sign_q;
    ea_d   = ea_q;
    eb_d   = eb_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    spec_d = spec_q;
    prod_d = prod_q;
    exp_d  = exp_q;
    frac_d = frac_q;
    grd_d  = grd_q;
    rnd_d  = rnd_q;
    stk_d  = stk_q;
    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          a_d = mult_operand_a;
          b_d = mult_operand_b;
        end
      end
      S_UNPACK: begin
        sign_d = a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
        ea_d   = ea_f;
        eb_d   = eb_f;
        ma_d   = {1'b1, fa_f};
        mb_d   = {1'b1, fb_f};
        // Special-case priority: NaN / inf*0, then inf, then zero.
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) spec_d = SP_NAN;
        else if (a_inf || b_inf)                                      spec_d = SP_INF;
        else if (a_zero || b_zero)                                    spec_d = SP_ZERO;
        else                                                          spec_d = SP_NONE;
      end
      S_MULT: begin
        prod_d = PW'(ma_q) * PW'(mb_q);
        exp_d  = EW'(ea_q) + EW'(eb_q) - BIAS;
      end
      S_NORM: begin
        // Product lies in [1,4); a set MSB means [2,4) and needs one right shift.
        if (prod_q[PW-1]) begin
          frac_d = prod_q[PW-2 -: ML];
          grd_d  = prod_q[ML];
          rnd_d  = prod_q[ML-1];
          stk_d  = |prod_q[ML-2:0];
          exp_d  = exp_q + EW'(1);
        end else begin
          frac_d = prod_q[PW-3 -: ML];
          grd_d  = prod_q[ML-1];
          rnd_d  = prod_q[ML-2];
          stk_d  = |prod_q[ML-3:0];
        end
      end
      default: ;
    endcase
  end

  // Rounding, special-case resolution and the registered handshake outputs.
  logic                 round_inc;
  logic [ML:0]          frac_sum;
  logic signed [EW-1:0] exp_rnd;

  always_comb begin
    round_inc = grd_q & (rnd_q | stk_q | frac_q[0]);
    // Carry out of the fraction means the significand rolled to 2.0: fraction is already zero.
    frac_sum  = {1'b0, frac_q} + (ML+1)'(round_inc);
    exp_rnd   = exp_q + EW'(frac_sum[ML]);
    result_d  = result_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: busy_d = mult_start;
      S_ROUND: begin
        ready_d = 1'b1;
        case (spec_q)
          SP_NAN:  result_d = QNAN;
          SP_INF:  result_d = {sign_q, {EXP_LEN{1'b1}}, {ML{1'b0}}};
          SP_ZERO: result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
          default: begin
            if (exp_rnd >= EXP_MAX)       result_d = {sign_q, {EXP_LEN{1'b1}}, {ML{1'b0}}};
            else if (exp_rnd <= EXP_ZERO) result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
            else                          result_d = {sign_q, exp_rnd[EXP_LEN-1:0], frac_sum[ML-1:0]};
          end
        endcase
      end
      default: ;
    endcase
  end

  assign mult_result       = result_q;
  assign mult_result_ready = ready_q;
  assign mult_busy         = busy_q;

endmodule

// File: tb/tb_fp_mult_responder.sv
// Self-checking bench for fp_mult_responder: expected products are queued when
// an operation is launched and compared whenever the ready pulse appears.
module tb_fp_mult_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic [31:0] mult_operand_a = '0;
  logic [31:0] mult_operand_b = '0;
  logic [31:0] mult_result;
  logic        mult_result_ready;
  logic        mult_busy;

  fp_mult_responder dut (
    .clock             (clock),
    .reset             (reset),
    .mult_start        (mult_start),
    .mult_operand_a    (mult_operand_a),
    .mult_operand_b    (mult_operand_b),
    .mult_result       (mult_result),
    .mult_result_ready (mult_result_ready),
    .mult_busy         (mult_busy)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          last_pulse_cyc = 0;
  int          prev_pulse_cyc = 0;
  logic [31:0] prev_exp = '0;
  logic [31:0] sb_val[$];
  string       sb_tag[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clock) cyc++;

  // Scoreboard consumer: every ready pulse must match the oldest queued product.
  always @(negedge clock) begin
    if (mult_result_ready) begin
      pulses++;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
      if (sb_val.size() == 0) begin
        check("unexpected_ready", 32'(sb_val.size()), 32'd1);
      end else begin
        check(sb_tag.pop_front(), mult_result, sb_val.pop_front());
      end
    end
  end

  // Launch one operation, check busy, hold of the old result, latency and busy release.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input string tag);
    int lat;
    bit seen;
    @(negedge clock);
    mult_start     = 1'b1;
    mult_operand_a = a;
    mult_operand_b = b;
    sb_val.push_back(exp_r);
    sb_tag.push_back(tag);
    @(posedge clock);
    #1;
    mult_start = 1'b0;
    check({tag, "_busy"}, 32'(mult_busy), 32'd1);
    check({tag, "_hold"}, mult_result, prev_exp);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clock);
      lat++;
      #1;
      if (mult_result_ready) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    @(posedge clock);
    #1;
    check({tag, "_busy_off"}, 32'(mult_busy), 32'd0);
    check({tag, "_ready_off"}, 32'(mult_result_ready), 32'd0);
    check({tag, "_stable"}, mult_result, exp_r);
    prev_exp = exp_r;
  endtask

  initial begin
    int p0;
    #3;
    check("rst_result", mult_result, 32'h0);
    check("rst_ready", 32'(mult_result_ready), 32'd0);
    check("rst_busy", 32'(mult_busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Arithmetic and rounding
    do_op(32'h40000000, 32'h40400000, 32'h40C00000, "mul_2x3");
    do_op(32'h3F800001, 32'h3F800001, 32'h3F800002, "rne_small");
    do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, "mul_1p5sq");
    do_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, "rne_tie_up");
    do_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, "rne_tie_even");
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "mul_allones");
    do_op(32'hC0000000, 32'hC0400000, 32'h40C00000, "neg_neg");
    // Sign and special cases
    do_op(32'hC0000000, 32'h3F000000, 32'hBF800000, "neg_half");
    do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
    do_op(32'hFF800000, 32'h40000000, 32'hFF800000, "neginf_x_2");
    do_op(32'h00000001, 32'h40000000, 32'h00000000, "denorm_ftz");
    do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
    do_op(32'h80000000, 32'h40000000, 32'h80000000, "negzero");
    // Range limits
    do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
    do_op(32'h00800000, 32'h00800000, 32'h00000000, "underflow");

    // Starts while busy are ignored; only the first operands produce a result.
    p0 = pulses;
    @(negedge clock);
    mult_start     = 1'b1;
    mult_operand_a = 32'h40000000;
    mult_operand_b = 32'h40400000;
    sb_val.push_back(32'h40C00000);
    sb_tag.push_back("ignore_busy_result");
    @(posedge clock);
    #1;
    mult_operand_a = 32'h41000000;
    mult_operand_b = 32'h41000000;
    repeat (3) @(posedge clock);
    #1;
    mult_start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("ignore_busy_pulses", 32'(pulses - p0), 32'd1);
    check("ignore_busy_value", mult_result, 32'h40C00000);
    prev_exp = 32'h40C00000;

    // Start held across two acceptance points: two back-to-back results, 5 cycles apart.
    p0 = pulses;
    @(negedge clock);
    mult_start     = 1'b1;
    mult_operand_a = 32'h3FC00000;
    mult_operand_b = 32'h40000000;
    sb_val.push_back(32'h40400000);
    sb_tag.push_back("held_first");
    sb_val.push_back(32'h40400000);
    sb_tag.push_back("held_second");
    repeat (9) @(posedge clock);
    #1;
    mult_start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("held_pulses", 32'(pulses - p0), 32'd2);
    check("held_spacing", 32'(last_pulse_cyc - prev_pulse_cyc), 32'd5);
    prev_exp = 32'h40400000;

    // Reset in the middle of an operation aborts it with no ready pulse.
    p0 = pulses;
    @(negedge clock);
    mult_start     = 1'b1;
    mult_operand_a = 32'h40400000;
    mult_operand_b = 32'h40400000;
    @(posedge clock);
    #1;
    mult_start = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_result", mult_result, 32'h0);
    check("abort_ready", 32'(mult_result_ready), 32'd0);
    check("abort_busy", 32'(mult_busy), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("abort_pulses", 32'(pulses - p0), 32'd0);
    check("abort_result_after", mult_result, 32'h0);
    check("abort_busy_after", 32'(mult_busy), 32'd0);
    prev_exp = 32'h0;
    do_op(32'h40000000, 32'h40000000, 32'h40800000, "after_abort");

    repeat (3) @(posedge clock);
    check("sb_drained", 32'(sb_val.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
